// File: rtl/mmio_pwm_bank.sv
// rtl/mmio_pwm_bank.sv - memory-mapped PWM bank with prescaler and double-buffered period/duty
// Claims a 256-byte window on the core store/load bus; shadows load into active at period boundaries.
module mmio_pwm_bank #(
  parameter int          NUM_CH     = 3,
  parameter int          PWM_W      = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_2000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write_mem,
  input  logic [2:0]        funct3,
  input  logic [31:0]       write_address,
  input  logic [31:0]       write_data,
  input  logic [31:0]       read_address,
  output logic [31:0]       read_data,
  output logic [NUM_CH-1:0] pwm_out
);

  typedef enum logic {ST_DISABLED, ST_RUNNING} state_t;

  state_t             r_state;
  logic [7:0]         r_presc;
  logic [7:0]         r_presc_cnt;
  logic [PWM_W-1:0]   r_cnt;
  logic [PWM_W-1:0]   r_period_sh;
  logic [PWM_W-1:0]   r_period_act;
  logic [PWM_W-1:0]   r_duty_sh  [NUM_CH];
  logic [PWM_W-1:0]   r_duty_act [NUM_CH];
  logic [NUM_CH-1:0]  r_pwm;
  logic [31:0]        r_read_data;

  logic               w_wr_en;
  logic [5:0]         w_wr_idx;
  logic               w_rd_hit;
  logic [5:0]         w_rd_idx;
  logic [31:0]        w_rd_val;
  logic               w_tick;
  logic               w_unused;

  assign w_wr_en  = write_mem && (write_address[31:8] == BASE_ADDR[31:8]) && (funct3 == 3'b010);
  assign w_wr_idx = write_address[7:2];
  assign w_rd_hit = (read_address[31:8] == BASE_ADDR[31:8]);
  assign w_rd_idx = read_address[7:2];
  assign w_tick   = (r_presc_cnt == r_presc);
  assign w_unused = ^{write_data, write_address[1:0], read_address[1:0]};

  // Readback always shows shadow values, never the active copies.
  always_comb begin
    w_rd_val = 32'd0;
    if (w_rd_hit) begin
      if (w_rd_idx == 6'd0) begin
        w_rd_val = {16'd0, r_presc, 7'd0, (r_state == ST_RUNNING)};
      end else if (w_rd_idx == 6'd1) begin
        w_rd_val = 32'(r_period_sh);
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_rd_idx == 6'(i + 2)) w_rd_val = 32'(r_duty_sh[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_DISABLED;
      r_presc      <= 8'd0;
      r_presc_cnt  <= 8'd0;
      r_cnt        <= '0;
      r_period_sh  <= '1;
      r_period_act <= '1;
      for (int i = 0; i < NUM_CH; i++) begin
        r_duty_sh[i]  <= '0;
        r_duty_act[i] <= '0;
      end
      r_pwm        <= {NUM_CH{ACTIVE_LOW}};
    end else begin
      if (w_wr_en && (w_wr_idx == 6'd0)) begin
        r_state <= write_data[0] ? ST_RUNNING : ST_DISABLED;
        r_presc <= write_data[15:8];
      end
      if (w_wr_en && (w_wr_idx == 6'd1)) r_period_sh <= write_data[PWM_W-1:0];
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_wr_en && (w_wr_idx == 6'(i + 2))) r_duty_sh[i] <= write_data[PWM_W-1:0];
      end

      case (r_state)
        ST_DISABLED: begin
          r_cnt        <= '0;
          r_presc_cnt  <= 8'd0;
          r_period_act <= r_period_sh;
          r_duty_act   <= r_duty_sh;
        end
        ST_RUNNING: begin
          if (w_tick) begin
            r_presc_cnt <= 8'd0;
            if (r_cnt == r_period_act) begin
              r_cnt        <= '0;
              r_period_act <= r_period_sh;
              r_duty_act   <= r_duty_sh;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else begin
            r_presc_cnt <= r_presc_cnt + 8'd1;
          end
        end
        default: r_state <= ST_DISABLED;
      endcase

      // Duty above the active period compares true for every count, giving 100% on.
      for (int i = 0; i < NUM_CH; i++) begin
        r_pwm[i] <= ((r_state == ST_RUNNING) && (r_cnt < r_duty_act[i])) ^ ACTIVE_LOW;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_read_data <= 32'd0;
    else        r_read_data <= w_rd_val;
  end

  assign read_data = r_read_data;
  assign pwm_out   = r_pwm;

endmodule

// File: tb/tb_mmio_pwm_bank.sv
// tb/tb_mmio_pwm_bank.sv - scoreboard bench for mmio_pwm_bank
// Expected pin/readback values are queued per cycle at drive time and popped by a negedge monitor.
module tb_mmio_pwm_bank;

  localparam logic [31:0] BASE   = 32'h0000_2000;
  localparam logic [31:0] A_CTRL = BASE;
  localparam logic [31:0] A_PER  = BASE + 32'h04;
  localparam logic [31:0] A_D0   = BASE + 32'h08;
  localparam logic [31:0] A_D1   = BASE + 32'h0C;
  localparam logic [31:0] A_D2   = BASE + 32'h10;

  logic        clk;
  logic        rst_n;
  logic        write_mem;
  logic [2:0]  funct3;
  logic [31:0] write_address;
  logic [31:0] write_data;
  logic [31:0] read_address;
  logic [31:0] read_data;
  logic [2:0]  pwm_out;

  mmio_pwm_bank #(
    .NUM_CH(3), .PWM_W(8), .BASE_ADDR(BASE), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .write_mem(write_mem), .funct3(funct3),
    .write_address(write_address), .write_data(write_data),
    .read_address(read_address), .read_data(read_data), .pwm_out(pwm_out)
  );

  typedef struct {
    int          cyc;
    logic [31:0] val;
  } exp_t;

  exp_t pwm_q[$];
  exp_t rd_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   k;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    while (pwm_q.size() > 0 && pwm_q[0].cyc <= cyc) begin
      e = pwm_q.pop_front();
      check_eq($sformatf("pwm@%0d", e.cyc), 32'(pwm_out), e.val);
    end
    while (rd_q.size() > 0 && rd_q[0].cyc <= cyc) begin
      e = rd_q.pop_front();
      check_eq($sformatf("rd@%0d", e.cyc), read_data, e.val);
    end
  end

  task automatic push_pwm(input int c, input logic [2:0] v);
    pwm_q.push_back('{cyc: c, val: {29'd0, v}});
  endtask

  task automatic push_rd(input int c, input logic [31:0] v);
    rd_q.push_back('{cyc: c, val: v});
  endtask

  // Pins after EN commit edge k: sample n reflects count floor((n-1)/(presc+1)) mod (per+1).
  task automatic push_run(input int kk, input int nmax, input int presc, input int per,
                          input int d0a, input int d0b, input int d1, input int d2,
                          input int off_from);
    for (int n = 1; n <= nmax; n++) begin
      int         src;
      int         c;
      logic [2:0] on;
      src   = (n - 1) / (presc + 1);
      c     = src % (per + 1);
      on[0] = c < (((src / (per + 1)) == 0) ? d0a : d0b);
      on[1] = c < d1;
      on[2] = c < d2;
      if (n >= off_from) on = 3'b000;
      push_pwm(kk + n, ~on);
    end
  endtask

  // Called at a negedge; the store commits on the following posedge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [2:0] f3 = 3'b010);
    write_mem     = 1'b1;
    funct3        = f3;
    write_address = a;
    write_data    = d;
    @(negedge clk);
    write_mem     = 1'b0;
    funct3        = 3'b000;
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [31:0] exp);
    read_address = a;
    push_rd(cyc + 1, exp);
    @(negedge clk);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n         = 1'b0;
    write_mem     = 1'b0;
    funct3        = 3'b000;
    write_address = 32'd0;
    write_data    = 32'd0;
    read_address  = A_PER;

    @(negedge clk);
    push_pwm(2, 3'b111); push_pwm(3, 3'b111);
    push_rd(2, 32'd0);   push_rd(3, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus_read(A_PER, 32'h0000_00FF);

    // Duty, double buffering, disable mid-run and re-enable
    bus_write(A_PER, 32'd9);
    bus_write(A_D0, 32'd3);
    bus_write(A_D1, 32'd0);
    bus_write(A_D2, 32'd10);
    bus_write(A_CTRL, 32'd1);
    k = cyc;
    push_run(k, 40, 0, 9, 3, 7, 0, 10, 36);
    wait_until(k + 5);
    bus_write(A_D0, 32'd7);
    bus_read(A_D0, 32'd7);
    wait_until(k + 34);
    bus_write(A_CTRL, 32'd0);
    wait_until(k + 40);
    bus_write(A_CTRL, 32'd1);
    k = cyc;
    push_run(k, 12, 0, 9, 7, 7, 0, 10, 1000);
    wait_until(k + 12);

    // Prescaler
    bus_write(A_CTRL, 32'd0);
    bus_write(A_PER, 32'd3);
    bus_write(A_D0, 32'd2);
    bus_write(A_CTRL, 32'h0000_0301);
    k = cyc;
    push_run(k, 40, 3, 3, 2, 2, 0, 10, 1000);
    bus_read(A_CTRL, 32'h0000_0301);
    wait_until(k + 40);
    bus_write(A_CTRL, 32'd0);

    // Bus filtering and readback
    bus_write(A_D0, 32'h55, 3'b000);
    bus_read(A_D0, 32'd2);
    bus_write(A_D0, 32'h66, 3'b001);
    bus_read(A_D0, 32'd2);
    bus_write(BASE + 32'h100, 32'h77);
    bus_read(BASE + 32'h100, 32'd0);
    bus_read(A_PER, 32'd3);
    bus_read(A_CTRL, 32'd0);
    bus_write(BASE + 32'h18, 32'h88);
    bus_read(BASE + 32'h18, 32'd0);
    bus_read(BASE + 32'h14, 32'd0);
    bus_read(A_D1, 32'd0);
    bus_read(A_D2, 32'd10);
    bus_read(BASE + 32'h06, 32'd3);
    bus_read(32'h0000_3004, 32'd0);
    bus_write(A_CTRL, 32'hFFFF_FF00);
    push_pwm(cyc + 1, 3'b111);
    bus_read(A_CTRL, 32'h0000_FF00);
    read_address = A_PER;
    push_rd(cyc + 1, 32'd3);
    bus_write(A_PER, 32'h0000_1234);
    bus_read(A_PER, 32'h0000_0034);

    // Reset while running
    bus_write(A_PER, 32'd9);
    bus_write(A_CTRL, 32'd1);
    k = cyc;
    push_pwm(k + 5, 3'b011);
    wait_until(k + 5);
    rst_n        = 1'b0;
    read_address = A_PER;
    push_pwm(cyc + 1, 3'b111);
    push_rd(cyc + 1, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    push_pwm(cyc + 1, 3'b111);
    push_pwm(cyc + 2, 3'b111);
    bus_read(A_PER, 32'h0000_00FF);
    bus_read(A_CTRL, 32'd0);
    bus_read(A_D0, 32'd0);
    bus_read(A_D2, 32'd0);

    for (int i = 0; i < 200 && (pwm_q.size() > 0 || rd_q.size() > 0); i++) @(negedge clk);
    check_eq("drain", 32'(pwm_q.size() + rd_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_pwm_bank.md
Name: mmio_pwm_bank

Overview:
- Parametrised memory-mapped PWM peripheral for the RISC-V SoC. It replaces fixed LED/RGB pins with NUM_CH independently dimmable outputs.
- Attaches to the same store/load bus the core drives into memory: write enable, funct3, write address/data, read address/data.
- Top level decodes nothing extra. The block claims its own address window and ignores everything outside it.
- Adds a global prescaler, a programmable period, per-channel duty, glitch-free double-buffered updates and selectable output polarity.

Parameters:
- NUM_CH, 3, number of PWM channels (1..62).
- PWM_W, 8, width of counter, period and duty registers (1..16).
- BASE_ADDR, 32'h0000_2000, window base; must be 256-byte aligned; window is BASE_ADDR..BASE_ADDR+0xFF.
- ACTIVE_LOW, 1, 1 = output driven 0 when "on" (iCE40 RGB/LED pins); 0 = active high.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- write_mem  in  1  store strobe, one cycle per store.
- funct3  in  3  store size; only 3'b010 (word) is honoured.
- write_address  in  32  store byte address.
- write_data  in  32  store data.
- read_address  in  32  load byte address.
- read_data  out  32  load data, registered.
- pwm_out  out  NUM_CH  channel outputs, registered.

Behaviour:
- Reset is synchronous and active-low: on a clk edge with rst_n=0, all state is cleared.
  - CTRL=0.
  - PERIOD shadow and active = 2^PWM_W-1.
  - All DUTY shadow and active = 0.
  - Prescaler and counter = 0.
  - read_data = 0.
  - pwm_out = all ACTIVE_LOW (every channel off).
- Reset mid-period aborts the period; the first cycle after release behaves as disabled.
- Window hit: addr[31:8]==BASE_ADDR[31:8]. Word offset = addr[7:2]; addr[1:0] are ignored.
- Register map (byte offsets):
  - 0x00 CTRL: bit0 EN, bits[15:8] PRESC, others read 0.
  - 0x04 PERIOD: bits[PWM_W-1:0].
  - 0x08+4*i DUTY[i], i < NUM_CH.
  - Unmapped offsets read 0; writes to them are ignored.
- Writes take effect when write_mem=1, the address hits and funct3=3'b010. Any other funct3 is ignored with no partial update.
- CTRL writes take effect on the next cycle.
- PERIOD/DUTY writes go to shadow registers only.
- Reads: read_data <= value at read_address one cycle later, matching the memory's 1-cycle latency. Returns shadow values; returns 0 on a miss.
- Read and write to the same register in the same cycle: read returns the old value.
- Prescaler: 8-bit counter. tick=1 when presc_cnt==PRESC, then presc_cnt<=0; otherwise presc_cnt increments. PRESC=0 gives a tick every cycle.
- Counter cnt (PWM_W bits) advances on tick only.
  - When cnt==period_active on a tick: cnt<=0 and all active registers <= shadows (period boundary).
  - Otherwise cnt<=cnt+1. No overflow is possible because cnt never exceeds period_active.
- Two states:
  - DISABLED (EN=0): cnt=0, presc_cnt=0, active registers continuously loaded from shadows, all outputs off.
  - RUNNING (EN=1): counting as above.
- DISABLED->RUNNING when EN is written 1; the first tick arrives PRESC+1 cycles later.
- RUNNING->DISABLED when EN is written 0; effective the next cycle, with no wait for period end.
- Channel on-condition: EN && (cnt < duty_active[i]).
  - duty=0 gives always off.
  - duty > period_active gives always on (100%).
- pwm_out[i] = on XOR ACTIVE_LOW, registered. This is one cycle of latency from cnt to pin.
- PWM frequency = f_clk / ((PRESC+1)*(PERIOD+1)).

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with ACTIVE_LOW=1 -> pwm_out=3'b111, read_data=0. A load at BASE+0x04 after release returns 0x0000_00FF.
- Duty basic: PERIOD=9, DUTY0=3, DUTY1=0, DUTY2=10, PRESC=0, EN=1 -> ch0 on 3 of every 10 cycles (ACTIVE_LOW low for 3). ch1 is never on; ch2 is always on.
- Double buffering: mid-period at cnt=5, write DUTY0=7 -> the current period still shows 3 on-cycles; the next period shows 7. A readback of DUTY0 returns 7 immediately.
- Prescaler: PRESC=3, PERIOD=3, DUTY0=2 -> ch0 period is 16 clk, on for 8 clk. The first edge occurs 4 cycles after the EN write.
- Bus filtering:
  - sb (funct3=000) to BASE+0x08 -> DUTY0 is unchanged.
  - sw to BASE+0x100 or BASE+0x0C+4*NUM_CH -> no register changes; a load returns 0.
- Disable and reset mid-run:
  - Clear EN at cnt=4 -> outputs off the next cycle and cnt=0. Re-enabling starts from cnt=0.
  - Assert rst_n=0 during RUNNING -> all registers return to reset values on that edge.
